accel_sample_fifo: RTL and testbench
====================================

ACCEL_SAMPLE_FIFO -- requirements
Module: accel_sample_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of x/y/z sample entries held; power of two, 4..64.
REQ-002 Parameter CW, default 16, width of the overflow counter.
REQ-003 sys_clk  in  1  single clock for the block; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on the rising edge of sys_clk.
REQ-005 x_data / y_data / z_data  in  16 each  filtered axis samples from the signal path, valid when sample_valid=1.
REQ-006 sample_valid  in  1  one-cycle strobe marking a new filtered sample triplet (the signal path's data_interrupt).
REQ-007 decim  in  4  decimation: keep 1 of every decim+1 strobes.
REQ-008 threshold  in  log2(DEPTH)+1  level at or above which irq asserts; 0 is treated as 1.
REQ-009 rd_req  in  1  pop request from the NIOS2 side.
REQ-010 flush  in  1  one-cycle request to empty the FIFO and clear overflow_count.
REQ-011 rd_x / rd_y / rd_z  out  16 each  popped sample triplet, valid when rd_valid=1.
REQ-012 rd_valid  out  1  one-cycle strobe, pop data present.
REQ-013 level  out  log2(DEPTH)+1  current number of stored entries, 0..DEPTH.
REQ-014 empty / full  out  1 each  level==0 / level==DEPTH.
REQ-015 overflow_count  out  CW  saturating count of accepted-for-push samples dropped because the FIFO was full.
REQ-016 irq  out  1  registered level flag, 1 while level >= effective threshold.

Function
REQ-017 Decimator: counter dcnt (4 bits); on sample_valid with dcnt==0 the triplet is a push candidate and dcnt loads decim; on sample_valid with dcnt!=0 the triplet is discarded and dcnt decrements; no change without sample_valid.
REQ-018 A change of decim takes effect only at the next reload; decim=0 makes every strobe a push candidate.
REQ-019 Storage: DEPTH x 48-bit array {x,y,z}, write pointer wp and read pointer rp, each log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-020 Push: candidate with level<DEPTH writes the array at wp, wp increments.
REQ-021 Pop: rd_req with level>0 registers entry rp onto rd_x/rd_y/rd_z and asserts rd_valid on the next cycle; rp increments; latency exactly 1 cycle from rd_req to rd_valid.
REQ-022 rd_req with level==0 is ignored: no rd_valid, no pointer change, rd_x/y/z hold.
REQ-023 rd_x/y/z hold their last popped value when rd_valid=0.
REQ-024 Push and pop in the same cycle with 0<level<DEPTH: both execute, level unchanged.
REQ-025 Push and pop same cycle at level==DEPTH: both execute, no overflow, level stays DEPTH.
REQ-026 Push and pop same cycle at level==0: push executes, pop ignored, level becomes 1; data first readable on a later rd_req.
REQ-027 Push candidate at level==DEPTH without a simultaneous valid pop: sample dropped, stored data untouched, overflow_count increments, holding at 2^CW-1.
REQ-028 flush: wp, rp, level and overflow_count go to 0 next cycle; flush overrides any push, pop or overflow in the same cycle; rd_valid=0 that cycle; dcnt unaffected.
REQ-029 irq, empty, full and level are registered, updated in the same cycle as the pointers, no combinational path from inputs.

Reset
REQ-030 reset overrides flush, push and pop; next cycle: wp=rp=0, level=0, dcnt=0, overflow_count=0, rd_valid=0, rd_x/y/z=0, empty=1, full=0, irq=0.
REQ-031 reset mid-operation discards all stored entries; a pop requested during reset produces no rd_valid.
REQ-032 First sample_valid after reset release is always a push candidate (dcnt=0).

Verification
REQ-033 decim=2, 9 strobes with x=1..9 -> entries x=1,4,7 stored, level=3; three pops -> rd_x=1,4,7 each 1 cycle after rd_req.
REQ-034 decim=0, DEPTH=16, 18 strobes no pops -> full=1, level=16, overflow_count=2; pops return x=1..16 in order, then empty=1.
REQ-035 level=16, push and rd_req same cycle -> overflow_count unchanged, level=16, rd_x=oldest entry.
REQ-036 level=0, push and rd_req same cycle -> no rd_valid, level=1; next rd_req -> rd_valid with pushed data.
REQ-037 threshold=4: pushes to level 4 -> irq=1 in same cycle level reads 4; one pop -> irq=0; threshold=0 with level=1 -> irq=1.
REQ-038 level=5, overflow_count=3, flush with simultaneous push -> level=0, overflow_count=0, empty=1; reset mid-stream -> all REQ-030 values next cycle.

Source files
------------

// File: rtl/accel_sample_fifo.sv
// rtl/accel_sample_fifo.sv - decimating x/y/z sample FIFO with level irq and overflow count
module accel_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic [15:0]              x_data,
  input  logic [15:0]              y_data,
  input  logic [15:0]              z_data,
  input  logic                     sample_valid,
  input  logic [3:0]               decim,
  input  logic [$clog2(DEPTH):0]   threshold,
  input  logic                     rd_req,
  input  logic                     flush,
  output logic [15:0]              rd_x,
  output logic [15:0]              rd_y,
  output logic [15:0]              rd_z,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic [CW-1:0]            overflow_count,
  output logic                     irq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [3:0]    dcnt;
  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          cand, pop_ok, push_ok, drop;
  logic [AW:0]   level_nx, thr_eff;

  always_comb begin
    cand    = sample_valid && (dcnt == 4'd0);
    pop_ok  = rd_req && (level != '0);
    // a pop in the same cycle frees the slot a full FIFO needs for the push
    push_ok = cand && (!full || pop_ok);
    drop    = cand && full && !pop_ok;
    level_nx = level;
    if (push_ok && !pop_ok)
      level_nx = level + 1'b1;
    else if (pop_ok && !push_ok)
      level_nx = level - 1'b1;
    thr_eff = (threshold == '0) ? (AW+1)'(1) : threshold;
  end

  always_ff @(posedge sys_clk) begin
    if (reset)
      dcnt <= 4'd0;
    else if (sample_valid)
      dcnt <= (dcnt == 4'd0) ? decim : dcnt - 4'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (!reset && !flush && push_ok)
      mem[wp] <= {x_data, y_data, z_data};
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wp             <= '0;
      rp             <= '0;
      level          <= '0;
      empty          <= 1'b1;
      full           <= 1'b0;
      irq            <= 1'b0;
      overflow_count <= '0;
      rd_valid       <= 1'b0;
      rd_x           <= '0;
      rd_y           <= '0;
      rd_z           <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (flush) begin
        wp             <= '0;
        rp             <= '0;
        level          <= '0;
        empty          <= 1'b1;
        full           <= 1'b0;
        irq            <= 1'b0;
        overflow_count <= '0;
      end else begin
        if (push_ok)
          wp <= wp + 1'b1;
        if (pop_ok) begin
          rp                 <= rp + 1'b1;
          {rd_x, rd_y, rd_z} <= mem[rp];
          rd_valid           <= 1'b1;
        end
        if (drop && (overflow_count != '1))
          overflow_count <= overflow_count + 1'b1;
        level <= level_nx;
        empty <= (level_nx == '0);
        full  <= (level_nx == FULL_LVL);
        irq   <= (level_nx >= thr_eff);
      end
    end
  end
endmodule

// File: tb/tb_accel_sample_fifo.sv
// tb/tb_accel_sample_fifo.sv - directed scoreboard bench for accel_sample_fifo
module tb_accel_sample_fifo;
  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] x_data = '0, y_data = '0, z_data = '0;
  logic        sample_valid = 1'b0;
  logic [3:0]  decim = '0;
  logic [4:0]  threshold = 5'd16;
  logic        rd_req = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] rd_x, rd_y, rd_z;
  logic        rd_valid;
  logic [4:0]  level;
  logic        empty, full;
  logic [15:0] overflow_count;
  logic        irq;

  accel_sample_fifo #(.DEPTH(16), .CW(16)) dut (
    .sys_clk(sys_clk), .reset(reset), .x_data(x_data), .y_data(y_data), .z_data(z_data),
    .sample_valid(sample_valid), .decim(decim), .threshold(threshold), .rd_req(rd_req),
    .flush(flush), .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z), .rd_valid(rd_valid),
    .level(level), .empty(empty), .full(full), .overflow_count(overflow_count), .irq(irq)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;
  logic [47:0] exp_q[$];
  int mdcnt = 0, mlevel = 0, movf = 0;
  logic mrdv = 1'b0;
  logic [47:0] mrd = '0;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model for the inputs now applied, clock once, then compare.
  task automatic cycle();
    bit cand, pop;
    int thr;
    if (reset) begin
      mdcnt = 0; mlevel = 0; movf = 0; mrdv = 1'b0; mrd = '0;
      exp_q.delete();
    end else begin
      cand = sample_valid && (mdcnt == 0);
      if (sample_valid) mdcnt = (mdcnt == 0) ? int'(decim) : mdcnt - 1;
      pop  = rd_req && (mlevel > 0);
      mrdv = 1'b0;
      if (flush) begin
        mlevel = 0; movf = 0;
        exp_q.delete();
      end else begin
        if (pop) begin mlevel--; mrdv = 1'b1; end
        if (cand) begin
          if (mlevel < 16) begin
            exp_q.push_back({x_data, y_data, z_data});
            mlevel++;
          end else if (movf < 65535) movf++;
        end
      end
    end
    thr = (threshold == 0) ? 1 : int'(threshold);
    @(posedge sys_clk);
    #1;
    chk("rd_valid", {47'd0, rd_valid}, {47'd0, mrdv});
    if (mrdv && rd_valid === 1'b1) begin
      if (exp_q.size() > 0) mrd = exp_q.pop_front();
      else chk("scoreboard_underflow", 48'd1, 48'd0);
    end
    chk("rd_xyz", {rd_x, rd_y, rd_z}, mrd);
    chk("level", {43'd0, level}, 48'(mlevel));
    chk("empty", {47'd0, empty}, {47'd0, mlevel == 0});
    chk("full", {47'd0, full}, {47'd0, mlevel == 16});
    chk("irq", {47'd0, irq}, {47'd0, mlevel >= thr});
    chk("overflow_count", {32'd0, overflow_count}, 48'(movf));
    sample_valid = 1'b0; rd_req = 1'b0; flush = 1'b0;
  endtask

  task automatic set_sample(input int v);
    x_data = 16'(v); y_data = 16'(v + 256); z_data = 16'(v + 512);
    sample_valid = 1'b1;
  endtask

  task automatic strobe(input int v);
    set_sample(v);
    cycle();
  endtask

  task automatic pop_one();
    rd_req = 1'b1;
    cycle();
  endtask

  initial begin
    reset = 1'b1;
    cycle();
    cycle();
    chk("reset_level", {43'd0, level}, 48'd0);
    chk("reset_empty", {47'd0, empty}, 48'd1);
    chk("reset_rdx", {32'd0, rd_x}, 48'd0);
    reset = 1'b0;
    cycle();

    // decimation by 3: keep x=1,4,7
    decim = 4'd2;
    for (int i = 1; i <= 9; i++) strobe(i);
    chk("dec_level", {43'd0, level}, 48'd3);
    for (int i = 0; i < 3; i++) begin
      pop_one();
      chk("dec_pop_x", {32'd0, rd_x}, 48'(1 + 3 * i));
    end
    cycle();
    pop_one();
    chk("empty_pop_hold", {32'd0, rd_x}, 48'd7);

    // fill past full with no decimation
    decim = 4'd0;
    for (int i = 1; i <= 18; i++) strobe(i);
    chk("fill_full", {47'd0, full}, 48'd1);
    chk("fill_ovf", {32'd0, overflow_count}, 48'd2);
    for (int i = 1; i <= 16; i++) begin
      pop_one();
      chk("drain_x", {32'd0, rd_x}, 48'(i));
    end
    chk("drain_empty", {47'd0, empty}, 48'd1);

    // push and pop together while full
    for (int i = 32; i < 48; i++) strobe(i);
    set_sample(99);
    rd_req = 1'b1;
    cycle();
    chk("fullpp_level", {43'd0, level}, 48'd16);
    chk("fullpp_ovf", {32'd0, overflow_count}, 48'd2);
    chk("fullpp_x", {32'd0, rd_x}, 48'd32);
    strobe(100);
    for (int i = 0; i < 11; i++) pop_one();
    chk("preflush_level", {43'd0, level}, 48'd5);
    chk("preflush_ovf", {32'd0, overflow_count}, 48'd3);
    set_sample(101);
    flush = 1'b1;
    cycle();
    chk("flush_level", {43'd0, level}, 48'd0);
    chk("flush_ovf", {32'd0, overflow_count}, 48'd0);

    // push and pop together while empty
    set_sample(200);
    rd_req = 1'b1;
    cycle();
    chk("emptypp_rdv", {47'd0, rd_valid}, 48'd0);
    chk("emptypp_level", {43'd0, level}, 48'd1);
    pop_one();
    chk("emptypp_x", {32'd0, rd_x}, 48'd200);

    // irq threshold behaviour
    threshold = 5'd4;
    cycle();
    for (int i = 0; i < 4; i++) begin
      strobe(300 + i);
      chk("thr_irq", {47'd0, irq}, {47'd0, i == 3});
    end
    pop_one();
    chk("thr_irq_pop", {47'd0, irq}, 48'd0);
    pop_one();
    pop_one();
    threshold = 5'd0;
    cycle();
    chk("thr0_irq", {47'd0, irq}, 48'd1);

    // reset mid-stream with a pop and strobe pending
    decim = 4'd3;
    strobe(400);
    strobe(401);
    reset = 1'b1;
    rd_req = 1'b1;
    set_sample(402);
    cycle();
    chk("midrst_rdv", {47'd0, rd_valid}, 48'd0);
    chk("midrst_level", {43'd0, level}, 48'd0);
    chk("midrst_rdx", {32'd0, rd_x}, 48'd0);
    reset = 1'b0;
    strobe(500);
    chk("post_rst_level", {43'd0, level}, 48'd1);
    pop_one();
    chk("post_rst_x", {32'd0, rd_x}, 48'd500);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
